// File: rtl/return_addr_stack.sv
// Circular return-address stack for the fetch stage.
// A decoded call pushes its link address. On a decoded return, the predicted
// return target and its select strobe are driven combinationally.
// A push onto a full stack overwrites the oldest entry.
// Optional feature macro: RAS_CHECKPOINT_EN. When it is defined, {tos, count}
// can be checkpointed into 4 slots, and a branch miss restores from the
// selected slot instead of flushing the stack.
module return_addr_stack #(
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3,
    parameter int ADDR_W = 32
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStall,
    input  logic              iCallCmd,
    input  logic [ADDR_W-1:0] iCallRetAddr,
    input  logic              iRetCmd,
    input  logic              iBranchMissCmd,
`ifdef RAS_CHECKPOINT_EN
    input  logic              iCheckpoint,
    input  logic [1:0]        iCheckpointId,
`endif
    output logic [ADDR_W-1:0] oRetAddr,
    output logic              oRetCmd,
    output logic              oEmpty,
    output logic              oFull,
    output logic [PTR_W:0]    oCount,
    output logic              oUnderflow
);

    localparam logic [PTR_W:0] FullCount = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  tos_q, tos_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              underflow_q, underflow_d;
    logic [PTR_W-1:0]  top_idx;
    logic              empty;

`ifdef RAS_CHECKPOINT_EN
    logic [PTR_W-1:0]  ckpt_tos_q [4];
    logic [PTR_W-1:0]  ckpt_tos_d [4];
    logic [PTR_W:0]    ckpt_count_q [4];
    logic [PTR_W:0]    ckpt_count_d [4];
`endif

    assign top_idx = tos_q - PTR_W'(1);
    assign empty   = (count_q == '0);

    // Read path: top entry and return strobe, no register stage
    always_comb begin
        oRetAddr   = empty ? '0 : mem_q[top_idx];
        oRetCmd    = iRetCmd & ~empty;
        oEmpty     = empty;
        oFull      = (count_q == FullCount);
        oCount     = count_q;
        oUnderflow = underflow_q;
    end

    // Next-state: miss > stall > push/pop, reset applied in the register block
    always_comb begin
        mem_d       = mem_q;
        tos_d       = tos_q;
        count_d     = count_q;
        underflow_d = 1'b0;
        if (iBranchMissCmd) begin
`ifdef RAS_CHECKPOINT_EN
            tos_d   = ckpt_tos_q[iCheckpointId];
            count_d = ckpt_count_q[iCheckpointId];
`else
            tos_d   = '0;
            count_d = '0;
`endif
        end else if (!iStall) begin
            case ({iCallCmd, iRetCmd})
                2'b10: begin
                    mem_d[tos_q] = iCallRetAddr;
                    tos_d        = tos_q + PTR_W'(1);
                    if (count_q != FullCount) count_d = count_q + (PTR_W+1)'(1);
                end
                2'b01: begin
                    if (empty) begin
                        underflow_d = 1'b1;
                    end else begin
                        tos_d   = top_idx;
                        count_d = count_q - (PTR_W+1)'(1);
                    end
                end
                2'b11: begin
                    // Tail call: replace the top in place; on empty it degrades to a push
                    if (empty) begin
                        mem_d[tos_q] = iCallRetAddr;
                        tos_d        = tos_q + PTR_W'(1);
                        count_d      = (PTR_W+1)'(1);
                        underflow_d  = 1'b1;
                    end else begin
                        mem_d[top_idx] = iCallRetAddr;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RAS_CHECKPOINT_EN
    // Checkpoint capture of the post-update pointer state
    always_comb begin
        ckpt_tos_d   = ckpt_tos_q;
        ckpt_count_d = ckpt_count_q;
        if (iCheckpoint && !iStall) begin
            ckpt_tos_d[iCheckpointId]   = tos_d;
            ckpt_count_d[iCheckpointId] = count_d;
        end
    end

    // Checkpoint slot registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < 4; i++) begin
                ckpt_tos_q[i]   <= '0;
                ckpt_count_q[i] <= '0;
            end
        end else begin
            ckpt_tos_q   <= ckpt_tos_d;
            ckpt_count_q <= ckpt_count_d;
        end
    end
`endif

    // Stack state registers with synchronous reset
    always_ff @(posedge iClk) begin
        if (iRst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            tos_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            tos_q       <= tos_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: doc/return_addr_stack.md
Name: return_addr_stack

Overview:
- Circular return-address stack (RAS) in the fetch stage; producer of the return target/command pair consumed by the PC-select mux.
- Pushes the link address on every decoded call and supplies the predicted return target combinationally on a decoded return.
- Branch-miss redirects flush the speculative stack state, or restore it from a checkpoint when the optional feature is compiled in.

Parameters:
DEPTH, 8, number of stack entries; power of two, >= 2
PTR_W, 3, log2(DEPTH); top-of-stack pointer width
ADDR_W, 32, return address width

Ports:
iClk  input  1  clock; all state updates on rising edge
iRst  input  1  synchronous active-high reset
iStall  input  1  fetch stall; blocks push/pop updates
iCallCmd  input  1  call (jump-and-link) decoded this cycle; push request
iCallRetAddr  input  ADDR_W  link address to push (next sequential PC)
iRetCmd  input  1  return decoded this cycle; pop request
iBranchMissCmd  input  1  misprediction redirect; flush/restore
oRetAddr  output  ADDR_W  current top-of-stack address (combinational)
oRetCmd  output  1  iRetCmd & !empty; select strobe for the PC mux
oEmpty  output  1  count == 0
oFull  output  1  count == DEPTH
oCount  output  PTR_W+1  valid entries, 0..DEPTH
oUnderflow  output  1  one-cycle registered pulse: pop attempted while empty

Behaviour:
- Clock and reset: one clock, iClk. Reset is synchronous and active-high on iRst.
- Storage: DEPTH x ADDR_W register array, write pointer tos (PTR_W bits), count (PTR_W+1 bits).
- Top entry is mem[tos-1] mod DEPTH.
- Reset values (iRst high at edge): tos=0, count=0, all entries=0, oUnderflow=0.
  - Resulting outputs: oRetAddr=0, oRetCmd=0, oEmpty=1, oFull=0, oCount=0.
- Read path:
  - oRetAddr = top entry when count>0, else 0. Zero latency, no register.
  - oRetCmd = iRetCmd & (count != 0). It is independent of iStall; the mux applies the stall.
- Update priority, highest first: iRst > iBranchMissCmd > iStall > push/pop.
- iBranchMissCmd:
  - Taken even while iStall=1.
  - Same-cycle iCallCmd/iRetCmd are ignored.
  - Without the feature: tos=0, count=0. Entry contents are unchanged but unreachable.
- iStall=1 (and no miss): no state change. oUnderflow deasserts next cycle.
- Push only (iCallCmd & !iRetCmd):
  - mem[tos] <= iCallRetAddr; tos <= tos+1 (wraps mod DEPTH).
  - count <= min(count+1, DEPTH).
  - Push when full overwrites the oldest entry (circular wrap); count stays DEPTH.
- Pop only (iRetCmd & !iCallCmd):
  - If count>0: tos <= tos-1 (wraps), count <= count-1.
  - If count==0: no change; oUnderflow=1 next cycle.
- Simultaneous call and return (e.g. tail call):
  - oRetAddr shows the old top this cycle.
  - At the edge, mem[tos-1] <= iCallRetAddr; tos and count unchanged.
  - If count==0, this is treated as a plain push (count=1) and oUnderflow pulses.
- oFull, oEmpty and oCount are driven directly from registered state.

Optional Feature:
RAS_CHECKPOINT_EN
- With the macro defined, add inputs iCheckpoint (1 bit) and iCheckpointId (2 bits), and a 4-slot checkpoint array of {tos, count}.
  - iCheckpoint=1 with !iStall at an edge saves the current post-update {tos, count} into slot iCheckpointId.
  - iBranchMissCmd restores {tos, count} from slot iCheckpointId instead of flushing. Entry contents are not restored.
  - Checkpoint slots reset to {0, 0}.
- Without the macro: the ports do not exist and a miss always flushes to empty.

Test Plan:
1. Reset, then push 0x100, 0x200, 0x300 on 3 cycles -> oCount=3, oRetAddr=0x300. Three pops -> oRetAddr reads 0x300, 0x200, 0x100, then oEmpty=1 and oRetAddr=0.
2. Push 9 addresses 0x10..0x90 with DEPTH=8 -> oFull=1, oCount=8. Eight pops return 0x90 down to 0x20; 0x10 was overwritten.
3. Pop on empty stack -> oRetCmd=0 the same cycle, oUnderflow=1 for exactly one following cycle, oCount stays 0.
4. Stack holds 0x40. Assert iCallCmd=1, iRetCmd=1, iCallRetAddr=0x80 -> oRetAddr=0x40 that cycle; next cycle oRetAddr=0x80, oCount=1.
5. Stack holds 2 entries. Assert iStall=1 with iCallCmd=1 -> no change. Then iStall=1 with iBranchMissCmd=1 -> next cycle oCount=0, oEmpty=1.
6. (RAS_CHECKPOINT_EN) Push 0xA0, checkpoint slot 1, push 0xB0 and 0xC0, then miss with slot 1 -> oCount=1, oRetAddr=0xA0.
